axi_slave_mem: RTL

AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

---
 rtl/axi_slave_mem_if.sv | 49 ++++
 rtl/axi_slave_mem.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem_if.sv
// AXI-style bus bundle for axi_slave_mem: AR/R/AW/W/B channels with 4-bit LEN and ID fields.
// The master modport drives requests; the slave modport is the memory side.
interface axi_slave_mem_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic [3:0]        arid;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [3:0]        rid;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awlen;
  logic [3:0]        awid;

  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic              wlast;

  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic [3:0]        bid;

  modport slave (
    input  arvalid, araddr, arlen, arid, rready,
    input  awvalid, awaddr, awlen, awid, wvalid, wdata, wlast, bready,
    output arready, rvalid, rdata, rresp, rlast, rid,
    output awready, wready, bvalid, bresp, bid
  );

  modport master (
    output arvalid, araddr, arlen, arid, rready,
    output awvalid, awaddr, awlen, awid, wvalid, wdata, wlast, bready,
    input  arready, rvalid, rdata, rresp, rlast, rid,
    input  awready, wready, bvalid, bresp, bid
  );
endinterface

// File: rtl/axi_slave_mem.sv
// Burst-capable memory slave with independent read and write FSMs; incrementing bursts wrap
// modulo the memory size, and the whole array is cleared by the asynchronous reset.
module axi_slave_mem #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input logic             clk,
  input logic             rst,
  axi_slave_mem_if.slave  bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  r_state_e          r_state;
  logic [ADDR_W-1:0] raddr;
  logic [3:0]        rlen;
  logic [4:0]        rbeat;

  w_state_e          w_state;
  logic [ADDR_W-1:0] waddr;
  logic [3:0]        wlen;
  logic [3:0]        wid;
  logic [4:0]        wbeat;
  logic              err;

  logic [ADDR_W-1:0] raddr_nxt;
  logic              w_fire;
  logic              w_final;
  logic              w_mismatch;

  assign raddr_nxt  = raddr + ADDR_W'(1);
  assign w_fire     = bus.wvalid && bus.wready;
  assign w_final    = (wbeat == {1'b0, wlen});
  assign w_mismatch = (bus.wlast != w_final);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (w_fire) begin
      mem[waddr] <= bus.wdata;
    end
  end

  // Reads sample mem before this edge's write lands, so a same-edge collision returns old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= R_IDLE;
      bus.arready <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.rdata   <= '0;
      bus.rresp   <= 2'b00;
      bus.rlast   <= 1'b0;
      bus.rid     <= '0;
      raddr       <= '0;
      rlen        <= '0;
      rbeat       <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          bus.arready <= 1'b1;
          if (bus.arvalid && bus.arready) begin
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b1;
            bus.rdata   <= mem[bus.araddr];
            bus.rresp   <= 2'b00;
            bus.rlast   <= (bus.arlen == 4'd0);
            bus.rid     <= bus.arid;
            raddr       <= bus.araddr;
            rlen        <= bus.arlen;
            rbeat       <= '0;
            r_state     <= R_DATA;
          end
        end
        R_DATA: begin
          if (bus.rvalid && bus.rready) begin
            if (bus.rlast) begin
              bus.rvalid  <= 1'b0;
              bus.rlast   <= 1'b0;
              bus.arready <= 1'b1;
              r_state     <= R_IDLE;
            end else begin
              raddr     <= raddr_nxt;
              bus.rdata <= mem[raddr_nxt];
              rbeat     <= rbeat + 5'd1;
              bus.rlast <= ((rbeat + 5'd1) == {1'b0, rlen});
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state     <= W_IDLE;
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      bus.bvalid  <= 1'b0;
      bus.bresp   <= 2'b00;
      bus.bid     <= '0;
      waddr       <= '0;
      wlen        <= '0;
      wid         <= '0;
      wbeat       <= '0;
      err         <= 1'b0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          bus.awready <= 1'b1;
          if (bus.awvalid && bus.awready) begin
            bus.awready <= 1'b0;
            bus.wready  <= 1'b1;
            waddr       <= bus.awaddr;
            wlen        <= bus.awlen;
            wid         <= bus.awid;
            wbeat       <= '0;
            err         <= 1'b0;
            w_state     <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            waddr <= waddr + ADDR_W'(1);
            wbeat <= wbeat + 5'd1;
            if (w_mismatch) err <= 1'b1;
            // Beat count alone ends the burst; WLAST only feeds the error flag.
            if (w_final) begin
              bus.wready <= 1'b0;
              bus.bvalid <= 1'b1;
              bus.bid    <= wid;
              bus.bresp  <= (err || w_mismatch) ? 2'b10 : 2'b00;
              w_state    <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bus.bvalid && bus.bready) begin
            bus.bvalid  <= 1'b0;
            bus.bresp   <= 2'b00;
            bus.bid     <= '0;
            err         <= 1'b0;
            bus.awready <= 1'b1;
            w_state     <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end
endmodule
